// File: rtl/dcache_pkg.sv
// Shared types and field-width helpers for the 2-way write-back data cache.
// Holds the controller state enum, the default geometry and the functions
// that derive the address field widths from a given geometry.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, COMMIT} state_e;

    localparam int unsigned ADDR_BITS      = 32;
    localparam int unsigned BYTE_OFF_BITS  = 2;
    localparam int unsigned DEF_SET_BITS   = 8;
    localparam int unsigned DEF_LINE_WORDS = 8;

    function automatic int unsigned off_bits(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned set_bits,
                                             input int unsigned line_words);
        return ADDR_BITS - BYTE_OFF_BITS - off_bits(line_words) - set_bits;
    endfunction

    localparam int unsigned DEF_OFF_BITS = off_bits(DEF_LINE_WORDS);
    localparam int unsigned DEF_TAG_BITS = tag_bits(DEF_SET_BITS, DEF_LINE_WORDS);

endpackage

// File: rtl/dcache_way.sv
// One way of the cache: per-set valid/dirty/tag plus the data array.
// Ports:
//   clk, reset            clock, synchronous active-high reset (clears valid/dirty)
//   idx, word_sel         set index and word within line for read and writes
//   valid, dirty, tag     status of the indexed set (combinational)
//   word                  indexed word (combinational)
//   word_we, byte_en,     byte-merge write of one word; also marks the set dirty
//   word_data
//   line_we, line_tag,    whole-line install: sets valid, tag and dirty
//   line_dirty, line_data
module dcache_way
    import dcache_pkg::*;
#(
    parameter int unsigned SET_BITS   = DEF_SET_BITS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned OFF_BITS   = off_bits(LINE_WORDS),
    parameter int unsigned TAG_BITS   = tag_bits(SET_BITS, LINE_WORDS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [SET_BITS-1:0]        idx,
    input  logic [OFF_BITS-1:0]        word_sel,
    output logic                       valid,
    output logic                       dirty,
    output logic [TAG_BITS-1:0]        tag,
    output logic [31:0]                word,
    input  logic                       word_we,
    input  logic [3:0]                 byte_en,
    input  logic [31:0]                word_data,
    input  logic                       line_we,
    input  logic [TAG_BITS-1:0]        line_tag,
    input  logic                       line_dirty,
    input  logic [LINE_WORDS*32-1:0]   line_data
);
    localparam int unsigned SETS = 1 << SET_BITS;

    logic [SETS-1:0]     valid_q;
    logic [SETS-1:0]     dirty_q;
    logic [TAG_BITS-1:0] tag_q  [SETS];
    logic [31:0]         data_q [SETS][LINE_WORDS];

    // Status bits are the only state that reset has to clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= line_dirty;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx] <= line_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                data_q[idx][w] <= line_data[w*32 +: 32];
            end
        end else if (word_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) data_q[idx][word_sel][b*8 +: 8] <= word_data[b*8 +: 8];
            end
        end
    end

    assign valid = valid_q[idx];
    assign dirty = dirty_q[idx];
    assign tag   = tag_q[idx];
    assign word  = data_q[idx][word_sel];

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative, write-back / write-allocate data cache.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   data_req, wren, byte_en,   CPU access (held stable while ram_abort is high)
//   cpu_addr, cpu_wr_data
//   cpu_rd_data                registered load data
//   hit                        combinational lookup hit (IDLE only)
//   ram_abort                  CPU stall while a miss is serviced
//   dram_wr_*                  victim write-back, one word per dram_wr_val
//   dram_rd_*                  line refill, one word per dram_rd_val
module dcache_2way
    import dcache_pkg::*;
#(
    parameter int unsigned SET_BITS   = DEF_SET_BITS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_req,
    input  logic        wren,
    input  logic [3:0]  byte_en,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wr_data,
    output logic [31:0] cpu_rd_data,
    output logic        hit,
    output logic        ram_abort,
    output logic        dram_wr_req,
    output logic [31:0] dram_wr_addr,
    output logic [31:0] dram_wr_data,
    input  logic        dram_wr_val,
    output logic        dram_rd_req,
    output logic [31:0] dram_rd_addr,
    input  logic [31:0] dram_rd_data,
    input  logic        dram_rd_val
);
    localparam int unsigned OFF  = off_bits(LINE_WORDS);
    localparam int unsigned TAGB = tag_bits(SET_BITS, LINE_WORDS);
    localparam int unsigned SETS = 1 << SET_BITS;
    localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);

    state_e state_q, state_d;

    logic [31:0]     cpu_rd_data_q;
    logic [SETS-1:0] lru_q;           // per set: index of the way to replace next
    logic [OFF-1:0]  wr_cnt_q, rd_cnt_q;
    logic [31:2]     addr_q;
    logic            wren_q, victim_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic [31:0]     stage_q [LINE_WORDS];

    logic [OFF-1:0]      cpu_word, cap_word, word_sel;
    logic [SET_BITS-1:0] cpu_idx, cap_idx, idx;
    logic [TAGB-1:0]     cpu_tag, cap_tag;
    logic                unused_addr;

    assign unused_addr = ^cpu_addr[1:0];
    assign cpu_word = cpu_addr[OFF+1:2];
    assign cpu_idx  = cpu_addr[OFF+SET_BITS+1:OFF+2];
    assign cpu_tag  = cpu_addr[31:OFF+SET_BITS+2];
    assign cap_word = addr_q[OFF+1:2];
    assign cap_idx  = addr_q[OFF+SET_BITS+1:OFF+2];
    assign cap_tag  = addr_q[31:OFF+SET_BITS+2];

    // Arrays look at the live CPU address in IDLE and the captured miss otherwise.
    assign idx      = (state_q == IDLE) ? cpu_idx : cap_idx;
    assign word_sel = (state_q == WRITEBACK) ? wr_cnt_q : cpu_word;

    logic [1:0]          way_valid, way_dirty, way_hit, word_we, line_we;
    logic [TAGB-1:0]     way_tag  [2];
    logic [31:0]         way_word [2];
    logic [LINE_WORDS*32-1:0] commit_line;
    logic                lookup_hit, victim_d;

    for (genvar w = 0; w < 2; w++) begin : g_way
        dcache_way #(
            .SET_BITS  (SET_BITS),
            .LINE_WORDS(LINE_WORDS)
        ) u_way (
            .clk       (clk),
            .reset     (reset),
            .idx       (idx),
            .word_sel  (word_sel),
            .valid     (way_valid[w]),
            .dirty     (way_dirty[w]),
            .tag       (way_tag[w]),
            .word      (way_word[w]),
            .word_we   (word_we[w]),
            .byte_en   (byte_en),
            .word_data (cpu_wr_data),
            .line_we   (line_we[w]),
            .line_tag  (cap_tag),
            .line_dirty(wren_q),
            .line_data (commit_line)
        );
    end

    always_comb begin
        way_hit[0] = way_valid[0] && (way_tag[0] == cpu_tag);
        way_hit[1] = way_valid[1] && (way_tag[1] == cpu_tag);
        lookup_hit = |way_hit;
        victim_d   = !way_valid[0] ? 1'b0 : !way_valid[1] ? 1'b1 : lru_q[cpu_idx];
        for (int w = 0; w < 2; w++) begin
            word_we[w] = (state_q == IDLE) && data_req && wren && way_hit[w];
            line_we[w] = (state_q == COMMIT) && (victim_q == 1'(w));
        end
    end

    // Staged refill line with any captured store merged into its word.
    always_comb begin
        for (int w = 0; w < LINE_WORDS; w++) commit_line[w*32 +: 32] = stage_q[w];
        if (wren_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) commit_line[int'(cap_word)*32 + b*8 +: 8] = wdata_q[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (data_req && !lookup_hit) begin
                    state_d = (way_valid[victim_d] && way_dirty[victim_d]) ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: if (dram_wr_val && wr_cnt_q == LAST_WORD) state_d = REFILL;
            REFILL:    if (dram_rd_val && rd_cnt_q == LAST_WORD) state_d = COMMIT;
            COMMIT:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        hit          = (state_q == IDLE) && data_req && lookup_hit;
        ram_abort    = (state_q != IDLE);
        dram_wr_req  = (state_q == WRITEBACK);
        dram_rd_req  = (state_q == REFILL);
        dram_wr_addr = '0;
        dram_wr_data = '0;
        dram_rd_addr = '0;
        if (dram_wr_req) begin
            dram_wr_addr = {way_tag[victim_q], cap_idx, {(OFF+2){1'b0}}};
            dram_wr_data = way_word[victim_q];
        end
        if (dram_rd_req) dram_rd_addr = {addr_q[31:OFF+2], {(OFF+2){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_rd_data_q <= '0;
            lru_q         <= '0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (data_req && lookup_hit) begin
                        lru_q[cpu_idx] <= ~way_hit[1];
                        if (!wren) cpu_rd_data_q <= way_word[way_hit[1]];
                    end
                end
                WRITEBACK: begin
                    if (dram_wr_val) wr_cnt_q <= (wr_cnt_q == LAST_WORD) ? '0 : wr_cnt_q + OFF'(1);
                end
                REFILL: begin
                    if (dram_rd_val) rd_cnt_q <= (rd_cnt_q == LAST_WORD) ? '0 : rd_cnt_q + OFF'(1);
                end
                COMMIT: begin
                    lru_q[cap_idx] <= ~victim_q;
                    if (!wren_q) cpu_rd_data_q <= stage_q[cap_word];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && data_req && !lookup_hit) begin
            addr_q   <= cpu_addr[31:2];
            wren_q   <= wren;
            be_q     <= byte_en;
            wdata_q  <= cpu_wr_data;
            victim_q <= victim_d;
        end
        if (state_q == REFILL && dram_rd_val) stage_q[rd_cnt_q] <= dram_rd_data;
    end

    assign cpu_rd_data = cpu_rd_data_q;

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way (SET_BITS=8, LINE_WORDS=8) with a small DRAM responder.
module tb_dcache_2way;
    logic        clk = 1'b0;
    logic        reset, data_req, wren, hit, ram_abort;
    logic [3:0]  byte_en;
    logic [31:0] cpu_addr, cpu_wr_data, cpu_rd_data;
    logic        dram_wr_req, dram_wr_val, dram_rd_req, dram_rd_val;
    logic [31:0] dram_wr_addr, dram_wr_data, dram_rd_addr, dram_rd_data;

    int checks = 0;
    int failures = 0;

    // Results of the last access() call
    logic [31:0] refill_base;
    int          wb_n, rd_n, wb_at_first_rd, commit_rd_n;
    logic [31:0] wb_addr_s, rd_addr_s, commit_rd;
    logic [31:0] wb_words [8];
    logic        first_hit, commit_seen, commit_follow;

    dcache_2way #(.SET_BITS(8), .LINE_WORDS(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_req    (data_req),
        .wren        (wren),
        .byte_en     (byte_en),
        .cpu_addr    (cpu_addr),
        .cpu_wr_data (cpu_wr_data),
        .cpu_rd_data (cpu_rd_data),
        .hit         (hit),
        .ram_abort   (ram_abort),
        .dram_wr_req (dram_wr_req),
        .dram_wr_addr(dram_wr_addr),
        .dram_wr_data(dram_wr_data),
        .dram_wr_val (dram_wr_val),
        .dram_rd_req (dram_rd_req),
        .dram_rd_addr(dram_rd_addr),
        .dram_rd_data(dram_rd_data),
        .dram_rd_val (dram_rd_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        data_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Presents one access and services the stall until the re-presented access hits.
    task automatic access(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input logic gapped);
        logic done, tgl, just_commit;
        int   last_val_cyc;
        done = 1'b0; tgl = 1'b0; last_val_cyc = -10;
        wb_n = 0; rd_n = 0; wb_at_first_rd = -1; commit_rd_n = -1;
        commit_seen = 1'b0; commit_follow = 1'b0; commit_rd = 'x;
        data_req = 1'b1; wren = we; byte_en = be; cpu_addr = addr; cpu_wr_data = wd;
        #1;
        first_hit = hit;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            just_commit = 1'b0;
            if (!ram_abort && hit) begin
                @(posedge clk); #1;
                done = 1'b1;
            end else begin
                dram_wr_val = dram_wr_req;
                if (dram_wr_req) begin
                    if (wb_n < 8) wb_words[wb_n] = dram_wr_data;
                    wb_addr_s = dram_wr_addr;
                    wb_n++;
                end
                if (dram_rd_req) begin
                    if (wb_at_first_rd < 0) wb_at_first_rd = wb_n;
                    tgl = !tgl;
                    if (!gapped || tgl) begin
                        dram_rd_val  = 1'b1;
                        dram_rd_data = refill_base + rd_n;
                        rd_addr_s    = dram_rd_addr;
                        rd_n++;
                        last_val_cyc = cyc;
                    end
                end
                if (ram_abort && !dram_wr_req && !dram_rd_req && !commit_seen) begin
                    commit_seen   = 1'b1;
                    just_commit   = 1'b1;
                    commit_follow = (cyc == last_val_cyc + 1);
                    commit_rd_n   = rd_n;
                end
                @(posedge clk); #1;
                dram_wr_val = 1'b0;
                dram_rd_val = 1'b0;
                if (just_commit) commit_rd = cpu_rd_data;
                #1;
            end
        end
        if (!done) check("access_timeout", 32'd0, 32'd1);
        data_req = 1'b0;
        wren = 1'b0;
    endtask

    initial begin
        reset = 1'b1; data_req = 1'b0; wren = 1'b0; byte_en = 4'h0;
        cpu_addr = '0; cpu_wr_data = '0;
        dram_wr_val = 1'b0; dram_rd_val = 1'b0; dram_rd_data = '0;
        refill_base = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_cpu_rd_data", cpu_rd_data, 32'h0);
        check("rst_ram_abort", ram_abort, 32'h0);
        check("rst_dram_wr_req", dram_wr_req, 32'h0);
        check("rst_dram_rd_req", dram_rd_req, 32'h0);
        check("rst_dram_wr_data", dram_wr_data, 32'h0);

        // Cold load miss
        refill_base = 32'hA0;
        access(32'h1004, 1'b0, 4'h0, 32'h0, 1'b0);
        check("cold_first_hit", first_hit, 32'h0);
        check("cold_rd_addr", rd_addr_s, 32'h1000);
        check("cold_rd_words", rd_n, 32'd8);
        check("cold_no_wb", wb_n, 32'd0);
        check("cold_commit_data", commit_rd, 32'hA1);
        check("cold_commit_follow", commit_follow, 32'h1);
        access(32'h1004, 1'b0, 4'h0, 32'h0, 1'b0);
        check("cold_reload_hit", first_hit, 32'h1);
        check("cold_reload_data", cpu_rd_data, 32'hA1);

        // Byte store
        access(32'h1008, 1'b1, 4'hF, 32'h11223344, 1'b0);
        check("st_full_hit", first_hit, 32'h1);
        access(32'h1008, 1'b1, 4'h3, 32'hDEADBEEF, 1'b0);
        check("st_byte_hit", first_hit, 32'h1);
        check("st_byte_no_dram", rd_n + wb_n, 32'd0);
        access(32'h1008, 1'b0, 4'h0, 32'h0, 1'b0);
        check("st_byte_data", cpu_rd_data, 32'h1122BEEF);
        access(32'h100C, 1'b1, 4'h0, 32'hFFFFFFFF, 1'b0);
        access(32'h100C, 1'b0, 4'h0, 32'h0, 1'b0);
        check("st_be0_data", cpu_rd_data, 32'hA3);

        // Idle request and stray DRAM valids are ignored
        cpu_addr = 32'h1004; data_req = 1'b0;
        #1;
        check("noreq_hit", hit, 32'h0);
        dram_rd_val = 1'b1; dram_wr_val = 1'b1; dram_rd_data = 32'hBAD;
        repeat (2) begin @(posedge clk); #1; end
        check("stray_val_abort", ram_abort, 32'h0);
        dram_rd_val = 1'b0; dram_wr_val = 1'b0;
        access(32'h1004, 1'b0, 4'h0, 32'h0, 1'b0);
        check("stray_val_hit", first_hit, 32'h1);
        check("stray_val_data", cpu_rd_data, 32'hA1);

        // LRU replacement
        reset_dut();
        refill_base = 32'h100; access(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0);
        refill_base = 32'h300; access(32'h3000, 1'b0, 4'h0, 32'h0, 1'b0);
        check("lru_fill1_miss", first_hit, 32'h0);
        access(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0);
        check("lru_touch_hit", first_hit, 32'h1);
        refill_base = 32'h500; access(32'h5000, 1'b0, 4'h0, 32'h0, 1'b0);
        check("lru_5000_miss", first_hit, 32'h0);
        check("lru_5000_no_wb", wb_n, 32'd0);
        check("lru_5000_data", cpu_rd_data, 32'h500);
        access(32'h1000, 1'b0, 4'h0, 32'h0, 1'b0);
        check("lru_1000_kept", first_hit, 32'h1);
        check("lru_1000_data", cpu_rd_data, 32'h100);
        refill_base = 32'h900; access(32'h3000, 1'b0, 4'h0, 32'h0, 1'b0);
        check("lru_3000_evicted", first_hit, 32'h0);

        // Dirty eviction
        reset_dut();
        refill_base = 32'h100; access(32'h1000, 1'b1, 4'hF, 32'h55, 1'b0);
        check("dirty_store_miss", first_hit, 32'h0);
        refill_base = 32'h300; access(32'h3000, 1'b0, 4'h0, 32'h0, 1'b0);
        check("dirty_3000_no_wb", wb_n, 32'd0);
        refill_base = 32'h500; access(32'h5000, 1'b0, 4'h0, 32'h0, 1'b0);
        check("dirty_wb_words", wb_n, 32'd8);
        check("dirty_wb_addr", wb_addr_s, 32'h1000);
        check("dirty_wb_word0", wb_words[0], 32'h55);
        check("dirty_wb_word1", wb_words[1], 32'h101);
        check("dirty_wb_word7", wb_words[7], 32'h107);
        check("dirty_wb_before_rd", wb_at_first_rd, 32'd8);
        check("dirty_rd_addr", rd_addr_s, 32'h5000);
        check("dirty_load_data", cpu_rd_data, 32'h500);

        // Reset in the middle of a refill
        reset_dut();
        cpu_addr = 32'h2004; wren = 1'b0; byte_en = 4'h0; data_req = 1'b1;
        @(posedge clk); #1;
        check("mid_rd_req", dram_rd_req, 32'h1);
        for (int k = 0; k < 3; k++) begin
            dram_rd_val = 1'b1; dram_rd_data = 32'hC0 + k;
            @(posedge clk); #1;
        end
        dram_rd_val = 1'b0;
        check("mid_still_refill", ram_abort, 32'h1);
        reset = 1'b1; data_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_rd_req", dram_rd_req, 32'h0);
        check("mid_rst_abort", ram_abort, 32'h0);

        // Reload misses again, refilled with a gapped valid stream
        refill_base = 32'h700;
        access(32'h2004, 1'b0, 4'h0, 32'h0, 1'b1);
        check("gap_miss_again", first_hit, 32'h0);
        check("gap_rd_words", rd_n, 32'd8);
        check("gap_commit_words", commit_rd_n, 32'd8);
        check("gap_commit_follow", commit_follow, 32'h1);
        check("gap_rd_addr", rd_addr_s, 32'h2000);
        check("gap_data", cpu_rd_data, 32'h701);
        access(32'h201C, 1'b0, 4'h0, 32'h0, 1'b0);
        check("gap_word7_hit", first_hit, 32'h1);
        check("gap_word7_data", cpu_rd_data, 32'h707);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_2way.md
DCACHE_2WAY -- requirements
Module: dcache_2way

Interface
REQ-001 SHALL provide parameter SET_BITS, default 8, meaning log2 of the number of sets (256 sets).
REQ-002 SHALL provide parameter LINE_WORDS, default 8, meaning 32-bit words per line; power of 2, range 2..32.
REQ-003 SHALL provide ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- data_req  in  1  CPU access request
- wren  in  1  1 = store, 0 = load
- byte_en  in  4  store byte lanes; bit i enables byte i
- cpu_addr  in  32  byte address; bits [1:0] ignored
- cpu_wr_data  in  32  store data
- cpu_rd_data  out  32  load data, registered
- hit  out  1  lookup hit, combinational
- ram_abort  out  1  CPU stall
- dram_wr_req  out  1  write-back in progress
- dram_wr_addr  out  32  line-aligned write-back address
- dram_wr_data  out  32  current write-back word
- dram_wr_val  in  1  DRAM accepted one write word
- dram_rd_req  out  1  refill in progress
- dram_rd_addr  out  32  line-aligned refill address
- dram_rd_data  in  32  refill word
- dram_rd_val  in  1  refill word valid

Function
REQ-004 SHALL split the address into fields. OFF = log2(LINE_WORDS). Word offset = [OFF+1:2]. Index = [OFF+SET_BITS+1:OFF+2]. Tag = remaining upper bits.
REQ-005 SHALL be 2-way set-associative and write-back/write-allocate, with per-way valid, dirty and tag bits and one LRU bit per set.
REQ-006 SHALL drive hit = (state IDLE) & data_req & (either way valid with matching tag).
REQ-007 On a load hit, SHALL register the addressed word onto cpu_rd_data at the next edge and set LRU to the other way.
REQ-008 On a store hit, SHALL merge cpu_wr_data into the addressed word per byte_en at the next edge, set dirty, and update LRU.
REQ-009 On a miss in IDLE, SHALL capture addr, wren, byte_en and wdata, then select the victim:
- invalid way0, else invalid way1, else the LRU way.
- next state WRITEBACK if the victim is valid and dirty, else REFILL.
REQ-010 In WRITEBACK, SHALL behave as follows:
- dram_wr_req = 1 and dram_wr_addr = {victim tag, index, OFF+2 zeros}.
- dram_wr_data is combinationally victim word wr_cnt.
- each dram_wr_val increments wr_cnt.
- after LINE_WORDS accepted words, move to REFILL.
REQ-011 In REFILL, SHALL behave as follows:
- dram_rd_req = 1 and dram_rd_addr = line-aligned captured address.
- each dram_rd_val stores dram_rd_data into staging word rd_cnt.
- after LINE_WORDS words, move to COMMIT.
REQ-012 In COMMIT, lasting one cycle, SHALL:
- write the staged line, tag and valid = 1 into the victim.
- on a store: set dirty = 1 and byte-merge the captured data.
- on a load: set dirty = 0 and load the requested word into cpu_rd_data.
- update LRU and return to IDLE.
REQ-013 SHALL drive ram_abort = 1 in WRITEBACK, REFILL and COMMIT, and 0 in IDLE.
REQ-014 The CPU holds its request stable while stalled. The re-presented access SHALL hit in IDLE and be handled per REQ-007/008; a repeated store SHALL be idempotent.
REQ-015 SHALL ignore dram_wr_val outside WRITEBACK and dram_rd_val outside REFILL. Gapped val sequences SHALL be counted word by word.
REQ-016 SHALL clear wr_cnt/rd_cnt on leaving their state and never wrap mid-line.
REQ-017 SHALL leave cache state unchanged when data_req = 0. A store with byte_en = 0 SHALL still set dirty and LRU.

Reset
REQ-018 On reset, SHALL at the next edge:
- go to IDLE and clear all valid, dirty and LRU bits and both counters.
- drive cpu_rd_data = 0, dram_wr_data = 0, dram_wr_req = dram_rd_req = ram_abort = 0.
REQ-019 A reset during WRITEBACK or REFILL SHALL abandon the transfer with no line committed. Data arrays need not be cleared.

Structure
REQ-020 Package dcache_pkg SHALL hold:
- state enum {IDLE, WRITEBACK, REFILL, COMMIT}
- default SET_BITS and LINE_WORDS
- field-width localparam derivations
REQ-021 Sub-module dcache_way SHALL hold one way's valid/dirty/tag/data arrays with a word-write byte-merge port and a line-write port; it is instantiated twice.

Verification (SET_BITS=8, LINE_WORDS=8)
REQ-022 Cold load miss: after reset, load 0x1004; refill 0xA0..0xA7 -> dram_rd_addr = 0x1000, cpu_rd_data = 0xA1 after COMMIT; the re-presented load hits.
REQ-023 Byte store: with word 0x1008 = 0x11223344, store 0xDEADBEEF with byte_en = 0011 -> a following load returns 0x1122BEEF and no DRAM traffic occurs.
REQ-024 LRU: fill 0x1000 (way0), then 0x3000 (way1, same index 0x80); load 0x1000; load 0x5000 -> way1 is replaced and 0x1000 still hits.
REQ-025 Dirty eviction: store 0x55 to 0x1000, then load 0x3000 and 0x5000 -> the second miss writes back 8 words to 0x1000 with word0 = 0x55 before refill begins.
REQ-026 Reset after 3 of 8 refill words -> dram_rd_req = 0 and ram_abort = 0 at the next edge; a reload of the same address misses again.
REQ-027 Refill with dram_rd_val asserted every other cycle -> exactly 8 words are captured in order and COMMIT follows the 8th valid.
